// File: rtl/mod_n_count_checker.sv
// mod_n_count_checker
// -------------------
// Receiving-side integrity monitor for a mod-N up/down counter stream.
// Each valid sample is classified against the previous accepted value as
// a hold, a +1 mod N step, a -1 mod N step, out of range, or an illegal
// jump. The result drives a three-state tracker (UNLOCKED / ACQUIRE /
// TRACK), a lock indicator, direction and wrap reporting, and error
// accounting. Every output is registered: a sample taken on rising edge k
// shows up in the outputs right after edge k.
//
// Handshake: i_valid qualifies i_Q for one cycle. There is no ready.
// A sample is consumed on every rising edge where i_valid=1. When
// i_valid=0, i_Q is ignored and the tracking state holds.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         asynchronous reset, active high
//   i_valid       i_Q is sampled this cycle
//   i_Q           counter value under check (WIDTH bits)
//   i_clr_err     synchronous clear of o_err_cnt and o_sticky_err
//   o_locked      stream tracked and trusted (TRACK with run >= LOCK_THRESH)
//   o_dir         direction of last legal step, 1 = up, 0 = down
//   o_wrap        one-cycle pulse on a legal N-1 -> 0 or 0 -> N-1 step
//   o_err         one-cycle pulse on an illegal sample
//   o_sticky_err  set on any error, held until i_clr_err
//   o_err_cnt     saturating error count (ERR_W bits)
//   o_last_Q      last accepted in-range sample
//   o_state       debug view of the tracker state (0 UNLOCKED, 1 ACQUIRE, 2 TRACK)

module mod_n_count_checker #(
   parameter int WIDTH       = 3,
   parameter int N           = 6,
   parameter int LOCK_THRESH = 4,
   parameter int ERR_W       = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_Q,
   input  logic             i_clr_err,
   output logic             o_locked,
   output logic             o_dir,
   output logic             o_wrap,
   output logic             o_err,
   output logic             o_sticky_err,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic [WIDTH-1:0] o_last_Q,
   output logic [1:0]       o_state
);

   localparam int RUN_W = $clog2(LOCK_THRESH + 1);

   localparam logic [WIDTH:0]   N_EXT   = (WIDTH+1)'(N);
   localparam logic [WIDTH-1:0] N_M1    = WIDTH'(N - 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_THRESH);
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      TRACK    = 2'd2
   } state_t;

   state_t           state_q, state_n;
   logic [WIDTH-1:0] last_q, last_n;
   logic             dir_q, dir_n;
   logic [RUN_W-1:0] run_q, run_n;
   logic             locked_n;
   logic             wrap_n;
   logic             err_n;
   logic             sticky_n;
   logic [ERR_W-1:0] cnt_n;

   // Sample classification against the last accepted value
   logic             oor;
   logic [WIDTH-1:0] up_val, dn_val;
   logic             is_hold, is_up, is_dn, is_step, step_wraps;

   always_comb begin
      oor     = ({1'b0, i_Q} >= N_EXT);
      up_val  = (last_q == N_M1) ? '0 : last_q + WIDTH'(1);
      dn_val  = (last_q == '0) ? N_M1 : last_q - WIDTH'(1);
      is_hold = (i_Q == last_q);
      is_up   = (i_Q == up_val);
      // When N=2 the up and down successors coincide; up wins.
      is_dn   = !is_up && (i_Q == dn_val);
      is_step = is_up || is_dn;
      step_wraps = (is_up && (last_q == N_M1)) || (is_dn && (last_q == '0));
   end

   // Next-state and next-output logic
   always_comb begin
      state_n = state_q;
      last_n  = last_q;
      dir_n   = dir_q;
      run_n   = run_q;
      wrap_n  = 1'b0;
      err_n   = 1'b0;

      case (state_q)
         UNLOCKED: begin
            if (i_valid) begin
               if (oor) begin
                  err_n = 1'b1;
               end else begin
                  last_n  = i_Q;
                  state_n = ACQUIRE;
               end
            end
         end

         ACQUIRE: begin
            if (i_valid) begin
               if (oor) begin
                  err_n   = 1'b1;
                  run_n   = '0;
                  state_n = UNLOCKED;
               end else if (is_hold) begin
                  state_n = ACQUIRE;
               end else if (is_step) begin
                  state_n = TRACK;
                  dir_n   = is_up;
                  run_n   = RUN_W'(1);
                  last_n  = i_Q;
                  wrap_n  = step_wraps;
               end else begin
                  err_n  = 1'b1;
                  last_n = i_Q;
               end
            end
         end

         TRACK: begin
            if (i_valid) begin
               if (oor) begin
                  err_n   = 1'b1;
                  run_n   = '0;
                  state_n = UNLOCKED;
               end else if (is_hold) begin
                  state_n = TRACK;
               end else if (is_step) begin
                  dir_n  = is_up;
                  run_n  = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
                  last_n = i_Q;
                  wrap_n = step_wraps;
               end else begin
                  err_n   = 1'b1;
                  run_n   = '0;
                  last_n  = i_Q;
                  state_n = ACQUIRE;
               end
            end
         end

         default: begin
            // Unused encoding: recover regardless of i_valid.
            state_n = UNLOCKED;
            run_n   = '0;
         end
      endcase

      locked_n = (state_n == TRACK) && (run_n >= RUN_MAX);

      // Clear wins over accumulation; an error in the clearing cycle still
      // counts as the first error of the new epoch.
      sticky_n = o_sticky_err;
      cnt_n    = o_err_cnt;
      if (i_clr_err) begin
         sticky_n = err_n;
         cnt_n    = err_n ? ERR_W'(1) : '0;
      end else if (err_n) begin
         sticky_n = 1'b1;
         cnt_n    = (o_err_cnt == ERR_MAX) ? ERR_MAX : o_err_cnt + ERR_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= UNLOCKED;
         last_q       <= '0;
         dir_q        <= 1'b0;
         run_q        <= '0;
         o_locked     <= 1'b0;
         o_wrap       <= 1'b0;
         o_err        <= 1'b0;
         o_sticky_err <= 1'b0;
         o_err_cnt    <= '0;
      end else begin
         state_q      <= state_n;
         last_q       <= last_n;
         dir_q        <= dir_n;
         run_q        <= run_n;
         o_locked     <= locked_n;
         o_wrap       <= wrap_n;
         o_err        <= err_n;
         o_sticky_err <= sticky_n;
         o_err_cnt    <= cnt_n;
      end
   end

   assign o_dir    = dir_q;
   assign o_last_Q = last_q;
   assign o_state  = state_q;

endmodule

// File: tb/tb_mod_n_count_checker.sv
// Directed bench for mod_n_count_checker (WIDTH=3, N=6, LOCK_THRESH=4,
// ERR_W=2). Each scenario task holds a table of hand-computed vectors:
// inputs for one clock plus the full expected output set after that edge.

module tb_mod_n_count_checker;

   localparam int WIDTH = 3;
   localparam int N     = 6;
   localparam int LT    = 4;
   localparam int ERR_W = 2;

   localparam logic [1:0] ST_U = 2'd0;
   localparam logic [1:0] ST_A = 2'd1;
   localparam logic [1:0] ST_T = 2'd2;

   logic             clk = 1'b0;
   logic             i_rst;
   logic             i_valid;
   logic [WIDTH-1:0] i_Q;
   logic             i_clr_err;
   logic             o_locked;
   logic             o_dir;
   logic             o_wrap;
   logic             o_err;
   logic             o_sticky_err;
   logic [ERR_W-1:0] o_err_cnt;
   logic [WIDTH-1:0] o_last_Q;
   logic [1:0]       o_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Observed outputs packed as {state, locked, dir, wrap, err, sticky, cnt, last}
   logic [11:0] obs;
   assign obs = {o_state, o_locked, o_dir, o_wrap, o_err, o_sticky_err, o_err_cnt, o_last_Q};

   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] q;
      logic             c;
      logic [1:0]       st;
      logic             lk;
      logic             dir;
      logic             wrap;
      logic             err;
      logic             sticky;
      logic [ERR_W-1:0] cnt;
      logic [WIDTH-1:0] last;
   } vec_t;

   mod_n_count_checker #(
      .WIDTH      (WIDTH),
      .N          (N),
      .LOCK_THRESH(LT),
      .ERR_W      (ERR_W)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .i_Q         (i_Q),
      .i_clr_err   (i_clr_err),
      .o_locked    (o_locked),
      .o_dir       (o_dir),
      .o_wrap      (o_wrap),
      .o_err       (o_err),
      .o_sticky_err(o_sticky_err),
      .o_err_cnt   (o_err_cnt),
      .o_last_Q    (o_last_Q),
      .o_state     (o_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers (stimulus only) ----------------
   function automatic vec_t mk(input logic v, input logic [WIDTH-1:0] q, input logic c,
                               input logic [1:0] st, input logic lk, input logic dir,
                               input logic wrap, input logic err, input logic sticky,
                               input logic [ERR_W-1:0] cnt, input logic [WIDTH-1:0] last);
      vec_t t;
      t.v = v; t.q = q; t.c = c; t.st = st; t.lk = lk; t.dir = dir; t.wrap = wrap;
      t.err = err; t.sticky = sticky; t.cnt = cnt; t.last = last;
      return t;
   endfunction

   function automatic logic [11:0] expv(input vec_t t);
      return {t.st, t.lk, t.dir, t.wrap, t.err, t.sticky, t.cnt, t.last};
   endfunction

   // Drive one cycle of inputs; return 1 time unit after the rising edge.
   task automatic send(input logic v, input logic [WIDTH-1:0] q, input logic c);
      i_valid   = v;
      i_Q       = q;
      i_clr_err = c;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      i_valid   = 1'b0;
      i_Q       = '0;
      i_clr_err = 1'b0;
      i_rst     = 1'b1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      i_valid   = 1'b0;
      i_Q       = '0;
      i_clr_err = 1'b0;
      i_rst     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (obs !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_hold: observed %b required %b", obs, 12'd0);
      end
      i_rst = 1'b0;
      send(1'b0, 3'd5, 1'b0);
      n_checks++;
      if (obs !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_idle: observed %b required %b", obs, 12'd0);
      end
   endtask

   task automatic test_up_count();
      vec_t tv[$];
      pulse_reset();
      tv.push_back(mk(1, 0, 0, ST_A, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 1, 0, ST_T, 0, 1, 0, 0, 0, 0, 1));
      tv.push_back(mk(1, 2, 0, ST_T, 0, 1, 0, 0, 0, 0, 2));
      tv.push_back(mk(1, 3, 0, ST_T, 0, 1, 0, 0, 0, 0, 3));
      tv.push_back(mk(1, 4, 0, ST_T, 1, 1, 0, 0, 0, 0, 4));
      tv.push_back(mk(1, 5, 0, ST_T, 1, 1, 0, 0, 0, 0, 5));
      tv.push_back(mk(1, 0, 0, ST_T, 1, 1, 1, 0, 0, 0, 0));
      tv.push_back(mk(1, 1, 0, ST_T, 1, 1, 0, 0, 0, 0, 1));
      foreach (tv[i]) begin
         send(tv[i].v, tv[i].q, tv[i].c);
         n_checks++;
         if (obs !== expv(tv[i])) begin
            n_fail++;
            $display("FAIL up_count[%0d]: observed %b required %b", i, obs, expv(tv[i]));
         end
      end
   endtask

   task automatic test_down_count();
      vec_t tv[$];
      pulse_reset();
      tv.push_back(mk(1, 3, 0, ST_A, 0, 0, 0, 0, 0, 0, 3));
      tv.push_back(mk(1, 2, 0, ST_T, 0, 0, 0, 0, 0, 0, 2));
      tv.push_back(mk(1, 1, 0, ST_T, 0, 0, 0, 0, 0, 0, 1));
      tv.push_back(mk(1, 0, 0, ST_T, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 5, 0, ST_T, 1, 0, 1, 0, 0, 0, 5));
      tv.push_back(mk(1, 4, 0, ST_T, 1, 0, 0, 0, 0, 0, 4));
      // direction reversal stays legal and locked
      tv.push_back(mk(1, 5, 0, ST_T, 1, 1, 0, 0, 0, 0, 5));
      tv.push_back(mk(1, 0, 0, ST_T, 1, 1, 1, 0, 0, 0, 0));
      foreach (tv[i]) begin
         send(tv[i].v, tv[i].q, tv[i].c);
         n_checks++;
         if (obs !== expv(tv[i])) begin
            n_fail++;
            $display("FAIL down_count[%0d]: observed %b required %b", i, obs, expv(tv[i]));
         end
      end
   endtask

   task automatic test_illegal_jump();
      vec_t tv[$];
      pulse_reset();
      tv.push_back(mk(1, 4, 0, ST_A, 0, 0, 0, 0, 0, 0, 4));
      tv.push_back(mk(1, 5, 0, ST_T, 0, 1, 0, 0, 0, 0, 5));
      tv.push_back(mk(1, 0, 0, ST_T, 0, 1, 1, 0, 0, 0, 0));
      tv.push_back(mk(1, 1, 0, ST_T, 0, 1, 0, 0, 0, 0, 1));
      tv.push_back(mk(1, 2, 0, ST_T, 1, 1, 0, 0, 0, 0, 2));
      tv.push_back(mk(1, 4, 0, ST_A, 0, 1, 0, 1, 1, 1, 4));
      tv.push_back(mk(1, 5, 0, ST_T, 0, 1, 0, 0, 1, 1, 5));
      // run restarted at 1: lock returns on the fourth step after re-entry
      tv.push_back(mk(1, 0, 0, ST_T, 0, 1, 1, 0, 1, 1, 0));
      tv.push_back(mk(1, 1, 0, ST_T, 0, 1, 0, 0, 1, 1, 1));
      tv.push_back(mk(1, 2, 0, ST_T, 1, 1, 0, 0, 1, 1, 2));
      foreach (tv[i]) begin
         send(tv[i].v, tv[i].q, tv[i].c);
         n_checks++;
         if (obs !== expv(tv[i])) begin
            n_fail++;
            $display("FAIL illegal_jump[%0d]: observed %b required %b", i, obs, expv(tv[i]));
         end
      end
   endtask

   task automatic test_out_of_range();
      vec_t tv[$];
      pulse_reset();
      tv.push_back(mk(1, 0, 0, ST_A, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 1, 0, ST_T, 0, 1, 0, 0, 0, 0, 1));
      tv.push_back(mk(1, 7, 0, ST_U, 0, 1, 0, 1, 1, 1, 1));
      tv.push_back(mk(1, 2, 0, ST_A, 0, 1, 0, 0, 1, 1, 2));
      tv.push_back(mk(1, 3, 0, ST_T, 0, 1, 0, 0, 1, 1, 3));
      foreach (tv[i]) begin
         send(tv[i].v, tv[i].q, tv[i].c);
         n_checks++;
         if (obs !== expv(tv[i])) begin
            n_fail++;
            $display("FAIL out_of_range[%0d]: observed %b required %b", i, obs, expv(tv[i]));
         end
      end
   endtask

   task automatic test_unlocked_oor();
      vec_t tv[$];
      pulse_reset();
      tv.push_back(mk(1, 6, 0, ST_U, 0, 0, 0, 1, 1, 1, 0));
      tv.push_back(mk(1, 5, 0, ST_A, 0, 0, 0, 0, 1, 1, 5));
      tv.push_back(mk(1, 7, 0, ST_U, 0, 0, 0, 1, 1, 2, 5));
      tv.push_back(mk(1, 0, 0, ST_A, 0, 0, 0, 0, 1, 2, 0));
      foreach (tv[i]) begin
         send(tv[i].v, tv[i].q, tv[i].c);
         n_checks++;
         if (obs !== expv(tv[i])) begin
            n_fail++;
            $display("FAIL unlocked_oor[%0d]: observed %b required %b", i, obs, expv(tv[i]));
         end
      end
   endtask

   task automatic test_hold_gaps();
      vec_t tv[$];
      pulse_reset();
      tv.push_back(mk(1, 4, 0, ST_A, 0, 0, 0, 0, 0, 0, 4));
      tv.push_back(mk(1, 4, 0, ST_A, 0, 0, 0, 0, 0, 0, 4));
      tv.push_back(mk(1, 5, 0, ST_T, 0, 1, 0, 0, 0, 0, 5));
      tv.push_back(mk(1, 0, 0, ST_T, 0, 1, 1, 0, 0, 0, 0));
      tv.push_back(mk(0, 3, 0, ST_T, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 1, 0, ST_T, 0, 1, 0, 0, 0, 0, 1));
      tv.push_back(mk(1, 1, 0, ST_T, 0, 1, 0, 0, 0, 0, 1));
      tv.push_back(mk(0, 6, 0, ST_T, 0, 1, 0, 0, 0, 0, 1));
      tv.push_back(mk(1, 1, 0, ST_T, 0, 1, 0, 0, 0, 0, 1));
      tv.push_back(mk(0, 3, 0, ST_T, 0, 1, 0, 0, 0, 0, 1));
      tv.push_back(mk(1, 1, 0, ST_T, 0, 1, 0, 0, 0, 0, 1));
      tv.push_back(mk(1, 2, 0, ST_T, 1, 1, 0, 0, 0, 0, 2));
      tv.push_back(mk(1, 2, 0, ST_T, 1, 1, 0, 0, 0, 0, 2));
      tv.push_back(mk(0, 7, 0, ST_T, 1, 1, 0, 0, 0, 0, 2));
      foreach (tv[i]) begin
         send(tv[i].v, tv[i].q, tv[i].c);
         n_checks++;
         if (obs !== expv(tv[i])) begin
            n_fail++;
            $display("FAIL hold_gaps[%0d]: observed %b required %b", i, obs, expv(tv[i]));
         end
      end
   endtask

   task automatic test_err_counter();
      vec_t tv[$];
      pulse_reset();
      tv.push_back(mk(1, 2, 0, ST_A, 0, 0, 0, 0, 0, 0, 2));
      tv.push_back(mk(1, 0, 0, ST_A, 0, 0, 0, 1, 1, 1, 0));
      tv.push_back(mk(1, 3, 0, ST_A, 0, 0, 0, 1, 1, 2, 3));
      tv.push_back(mk(1, 0, 0, ST_A, 0, 0, 0, 1, 1, 3, 0));
      tv.push_back(mk(1, 3, 0, ST_A, 0, 0, 0, 1, 1, 3, 3));
      tv.push_back(mk(1, 0, 0, ST_A, 0, 0, 0, 1, 1, 3, 0));
      tv.push_back(mk(0, 5, 1, ST_A, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 3, 0, ST_A, 0, 0, 0, 1, 1, 1, 3));
      tv.push_back(mk(1, 0, 0, ST_A, 0, 0, 0, 1, 1, 2, 0));
      tv.push_back(mk(1, 3, 1, ST_A, 0, 0, 0, 1, 1, 1, 3));
      tv.push_back(mk(1, 4, 0, ST_T, 0, 1, 0, 0, 1, 1, 4));
      tv.push_back(mk(1, 0, 0, ST_A, 0, 1, 0, 1, 1, 2, 0));
      foreach (tv[i]) begin
         send(tv[i].v, tv[i].q, tv[i].c);
         n_checks++;
         if (obs !== expv(tv[i])) begin
            n_fail++;
            $display("FAIL err_counter[%0d]: observed %b required %b", i, obs, expv(tv[i]));
         end
      end

      // Asynchronous reset between clock edges
      i_valid = 1'b0;
      #2;
      i_rst = 1'b1;
      #1;
      n_checks++;
      if (obs !== 12'd0) begin
         n_fail++;
         $display("FAIL async_reset: observed %b required %b", obs, 12'd0);
      end
      @(posedge clk);
      #1;
      i_rst = 1'b0;

      // First valid in-range sample after reset is accepted cleanly
      send(1'b1, 3'd3, 1'b0);
      n_checks++;
      if (obs !== {ST_A, 7'b0, 3'd3}) begin
         n_fail++;
         $display("FAIL post_reset_first: observed %b required %b", obs, {ST_A, 7'b0, 3'd3});
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_up_count();
      test_down_count();
      test_illegal_jump();
      test_out_of_range();
      test_unlocked_oor();
      test_hold_gaps();
      test_err_counter();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_n_count_checker.md
Name: mod_n_count_checker

Overview:
Receiving-side checker for the mod-N up/down counter output stream. It samples a counter value on every valid cycle and decides whether each new value is a legal successor of the previous one: hold, +1 mod N, or -1 mod N. It reports direction, wrap events, errors and lock status. It sits next to the counter in the same clock domain, as a run-time integrity monitor and as a bench-reusable scoreboard.

Parameters:
WIDTH, 3, width of the sampled counter value.
N, 6, modulus; legal values are 0..N-1; requires 2 <= N <= 2^WIDTH.
LOCK_THRESH, 4, consecutive legal non-hold steps required before o_locked asserts (>=1).
ERR_W, 8, width of the saturating error counter.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  asynchronous reset, active-high.
i_valid  input  1  i_Q is sampled this cycle.
i_Q  input  WIDTH  counter value under check.
i_clr_err  input  1  synchronous clear of o_err_cnt and o_sticky_err.
o_locked  output  1  stream is being tracked and trusted.
o_dir  output  1  direction of last legal step: 1 = up, 0 = down.
o_wrap  output  1  one-cycle pulse on a legal wrap step.
o_err  output  1  one-cycle pulse on an illegal sample.
o_sticky_err  output  1  set on any error; held until i_clr_err.
o_err_cnt  output  ERR_W  saturating count of errors.
o_last_Q  output  WIDTH  last accepted (in-range) sample.

Behaviour:
- Reset (asynchronous, i_rst=1): state=UNLOCKED. All outputs are 0, including o_last_Q, the internal run counter and o_err_cnt.
- All outputs are registered. A sample taken at rising edge k is reflected in the outputs after edge k (1-cycle latency).
- If i_valid=0: state, o_last_Q, o_dir and the run counter hold; o_wrap=0 and o_err=0.
- Definitions for previous value p and sample s:
  - out_of_range: s >= N.
  - up step: s == (p==N-1 ? 0 : p+1).
  - down step: s == (p==0 ? N-1 : p-1).
  - hold: s == p.
  - If a sample qualifies as both up and down step (N=2), it is classified as an up step.
- UNLOCKED:
  - In-range sample: o_last_Q<=s, go to ACQUIRE, no error.
  - Out-of-range sample: o_err pulse, stay in UNLOCKED.
- ACQUIRE:
  - hold: stay.
  - up or down step: go to TRACK, o_dir set accordingly, run=1.
  - Out-of-range: error, go to UNLOCKED.
  - Other in-range value: error, o_last_Q<=s, stay in ACQUIRE.
- TRACK:
  - hold: legal; run unchanged.
  - up or down step: legal; o_dir updated (direction reversals are legal); run increments, saturating at LOCK_THRESH.
  - Out-of-range: error, run=0, go to UNLOCKED.
  - Other in-range value: error, run=0, o_last_Q<=s, go to ACQUIRE.
- o_locked = (state==TRACK) && (run >= LOCK_THRESH). It deasserts on the output edge of any error.
- o_wrap pulses on a legal step from N-1 to 0 (up) or from 0 to N-1 (down), in ACQUIRE or TRACK. It never pulses on the UNLOCKED first sample.
- Every legal sample updates o_last_Q<=s.
- Error accounting:
  - Each error sets o_sticky_err and increments o_err_cnt, saturating at 2^ERR_W-1.
  - i_clr_err has priority: the count goes to 0 and sticky to 0.
  - If an error coincides with i_clr_err, the count becomes 1, sticky becomes 1, and o_err pulses.
- Reset asserted mid-stream returns immediately to UNLOCKED with all outputs 0. The first valid sample after reset is never an error unless it is out of range.
- Unused state encodings recover to UNLOCKED on the next edge.

Test Plan:
1. Reset, then valid samples 0,1,2,3,4,5,0,1 (N=6, LOCK_THRESH=4):
   - o_locked rises on the output edge of sample 4.
   - o_wrap pulses once on the 5->0 step.
   - o_dir=1 throughout; o_err never asserts; o_err_cnt=0.
2. Samples 3,2,1,0,5,4:
   - o_dir=0.
   - o_wrap pulses on 0->5.
   - o_locked asserts after 4 down steps.
3. Locked up-count at 2, then sample 4:
   - o_err 1-cycle pulse, o_locked=0, o_sticky_err=1, o_err_cnt=1, o_last_Q=4, state ACQUIRE.
   - Next sample 5: TRACK with run=1, no error.
4. Sample 7 (out of range) in TRACK:
   - o_err pulses, state UNLOCKED, o_last_Q unchanged.
   - Next sample 2 is accepted without error.
5. Holds and gaps: samples 1,1,1 with i_valid toggling 1/0:
   - No error, run unchanged, o_locked unchanged, no o_wrap.
6. Error counter (ERR_W=2):
   - Five alternating illegal samples 0,3,0,3,0 -> o_err_cnt saturates at 3.
   - i_clr_err coincident with a further error -> o_err_cnt=1, o_sticky_err=1.
   - Asserting i_rst mid-stream -> all outputs 0 asynchronously.
